dbus_simple_to_axi: RTL

Bridge from the VexRiscv DBusSimple port to a single-beat AXI4 master that drives the `s00_axi_*` slave port of the 1x2 AXI interconnect. It handles one transaction at a time, generates AXI write strobes from access size and low address bits, and returns read data with an error flag. It is the only AXI master in front of the interconnect.

---
 rtl/dbus_simple_to_axi_pkg.sv | 35 +++
 rtl/dbus_simple_to_axi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_simple_to_axi_pkg.sv
// Shared types and helpers for the VexRiscv DBusSimple to AXI4 single-beat bridge.
package dbus_simple_to_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Size encoding: 0 byte, 1 half, 2 and 3 word.
  function automatic logic [3:0] size_addr_to_strb(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 4'b0001 << addr_lo;
      2'd1:    return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dbus_simple_to_axi.sv
// VexRiscv DBusSimple to single-beat AXI4 master bridge, one transaction in flight.
// Handshakes: a valid, once raised, holds with stable payload until its ready is seen high.
module dbus_simple_to_axi
  import dbus_simple_to_axi_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0,
  parameter logic [3:0]          AXI_CACHE  = 4'b0011,
  parameter logic [2:0]          AXI_PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [31:0]           cmd_data,
  input  logic [1:0]            cmd_size,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_error,
  output logic                  err_write,
  input  logic                  err_clear,
  output logic [2:0]            dbg_state,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic                  m_axi_awuser,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wuser,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_buser,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            strb_q, strb_d;
  logic [1:0]            size_q, size_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  err_write_q, err_write_d;
  logic                  err_set;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    size_d      = size_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    err_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_address;
          data_d = cmd_data;
          strb_d = size_addr_to_strb(cmd_size, cmd_address[1:0]);
          size_d = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
          // Misaligned accesses never reach AXI; they are answered locally.
          if (is_misaligned(cmd_size, cmd_address[1:0])) begin
            if (cmd_wr) begin
              err_set = 1'b1;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_error_d = 1'b1;
              rsp_data_d  = '0;
            end
          end else if (cmd_wr) begin
            state_d     = S_WRITE;
            cmd_ready_d = 1'b0;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
          end else begin
            state_d     = S_READ;
            cmd_ready_d = 1'b0;
            arvalid_d   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (aw_done_q && w_done_q) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end else begin
          if (awvalid_q && m_axi_awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (wvalid_q && m_axi_wready) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
          err_set     = m_axi_bresp[1];
        end
      end
      S_READ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = m_axi_rdata;
          rsp_error_d = m_axi_rresp[1];
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

    err_write_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err_write_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      size_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      err_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      size_q      <= size_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      err_write_q <= err_write_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign err_write = err_write_q;
  assign dbg_state = state_q;

  assign m_axi_awid     = AXI_ID;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = {1'b0, size_q};
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = AXI_CACHE;
  assign m_axi_awprot   = AXI_PROT;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awuser   = 1'b0;
  assign m_axi_awvalid  = awvalid_q;

  assign m_axi_wdata  = data_q;
  assign m_axi_wstrb  = strb_q;
  assign m_axi_wlast  = 1'b1;
  assign m_axi_wuser  = 1'b0;
  assign m_axi_wvalid = wvalid_q;

  assign m_axi_bready = bready_q;

  assign m_axi_arid     = AXI_ID;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = {1'b0, size_q};
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = AXI_CACHE;
  assign m_axi_arprot   = AXI_PROT;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_aruser   = 1'b0;
  assign m_axi_arvalid  = arvalid_q;

  assign m_axi_rready = rready_q;

  // IDs, user sidebands and rlast carry no information for a single-beat, single-ID master.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_rlast, m_axi_ruser};

endmodule
